// File: rtl/systolic_bist_engine.sv
// rtl/systolic_bist_engine.sv - pattern generator / MISR compactor BIST engine for the systolic array
//
// Purpose: drives stimulus patterns into the array's external lanes, compacts the
// array's result bus into a MISR through a latency-aligned capture window, and
// compares the final signature against a golden value.
//
// Ports:
//   clk_i, rstn_async_i        clock, asynchronous active-low reset
//   start_i                    start pulse (accepted in IDLE/DONE only)
//   mode_i                     0=LFSR 1=walking-one 2=constant 3=counter
//   num_patterns_i, seed_i     run length and generator seed
//   stop_code_en_i, stop_code_i early-stop control
//   latency_i                  array latency (0 -> 1, clamped to MAX_LAT)
//   golden_sig_i               expected signature, sampled in COMPARE
//   result_i                   array result bus
//   pattern_o, pattern_valid_o stimulus (inputs low ROW*WIDTH bits, weights above)
//   signature_o                current MISR
//   patterns_sent_o            patterns issued this run
//   busy_o, done_o, pass_o, stopped_o  run status
module systolic_bist_engine #(
  parameter int          WIDTH        = 8,
  parameter int          ROW          = 4,
  parameter int          COL          = 4,
  parameter int          DRIVER_WIDTH = WIDTH * (ROW + COL),
  parameter int          CNT_W        = 16,
  parameter int          MAX_LAT      = 16,
  parameter logic [63:0] POLY         = 64'hD800_0000_0000_0000
) (
  input  logic                             clk_i,
  input  logic                             rstn_async_i,
  input  logic                             start_i,
  input  logic [1:0]                       mode_i,
  input  logic [CNT_W-1:0]                 num_patterns_i,
  input  logic [DRIVER_WIDTH-1:0]          seed_i,
  input  logic                             stop_code_en_i,
  input  logic [DRIVER_WIDTH-1:0]          stop_code_i,
  input  logic [$clog2(MAX_LAT+1)-1:0]     latency_i,
  input  logic [DRIVER_WIDTH-1:0]          golden_sig_i,
  input  logic [DRIVER_WIDTH-1:0]          result_i,
  output logic [DRIVER_WIDTH-1:0]          pattern_o,
  output logic                             pattern_valid_o,
  output logic [DRIVER_WIDTH-1:0]          signature_o,
  output logic [CNT_W-1:0]                 patterns_sent_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             pass_o,
  output logic                             stopped_o
);

  localparam int DW    = DRIVER_WIDTH;
  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int TAP_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [DW-1:0] POLY_L = DW'(POLY);

  localparam logic [1:0] M_LFSR  = 2'd0;
  localparam logic [1:0] M_WALK  = 2'd1;
  localparam logic [1:0] M_CONST = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRIVE, S_DRAIN, S_COMPARE, S_DONE
  } state_t;

  function automatic logic [DW-1:0] step(input logic [DW-1:0] x);
    return (x >> 1) ^ (x[0] ? POLY_L : '0);
  endfunction

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [CNT_W-1:0]       num_q, num_d;
  logic                   stop_en_q, stop_en_d;
  logic [DW-1:0]          stop_q, stop_d;
  logic [TAP_W-1:0]       tap_q, tap_d;     // latency - 1, index of the capture tap
  logic [DW-1:0]          gen_q, gen_d;
  logic [DW-1:0]          misr_q, misr_d;
  logic [CNT_W-1:0]       sent_q, sent_d;
  logic [MAX_LAT-1:0]     vld_q, vld_d;     // bit i holds the valid issued i+1 cycles ago
  logic                   pass_q, pass_d;
  logic                   stopped_q, stopped_d;

  logic                   drive_valid;
  logic                   capture;
  logic                   pending;
  logic [MAX_LAT-1:0]     tap_mask;
  logic [LAT_W-1:0]       lat_eff;
  logic [DW-1:0]          gen_init;
  logic                   last_pat;
  logic                   stop_hit;

  assign drive_valid = (state_q == S_DRIVE);
  assign capture     = vld_q[tap_q];
  // Taps 1..latency; taps beyond the capture point hold already-compacted slots.
  assign tap_mask    = ((MAX_LAT'(1) << tap_q) << 1) - MAX_LAT'(1);
  assign pending     = |(vld_q & tap_mask);
  assign last_pat    = (sent_q == (num_q - CNT_W'(1)));
  assign stop_hit    = stop_en_q && (gen_q == stop_q);

  always_comb begin
    lat_eff = latency_i;
    if (latency_i == '0) begin
      lat_eff = LAT_W'(1);
    end else if (latency_i > LAT_W'(MAX_LAT)) begin
      lat_eff = LAT_W'(MAX_LAT);
    end
  end

  always_comb begin
    case (mode_i)
      M_LFSR:  gen_init = (seed_i == '0) ? DW'(1) : seed_i;
      M_WALK:  gen_init = DW'(1);
      default: gen_init = seed_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    num_d     = num_q;
    stop_en_d = stop_en_q;
    stop_d    = stop_q;
    tap_d     = tap_q;
    gen_d     = gen_q;
    sent_d    = sent_q;
    pass_d    = pass_q;
    stopped_d = stopped_q;
    vld_d     = (vld_q << 1) | MAX_LAT'(drive_valid);
    misr_d    = capture ? (step(misr_q) ^ result_i) : misr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_LOAD;
          mode_d    = mode_i;
          num_d     = num_patterns_i;
          stop_en_d = stop_code_en_i;
          stop_d    = stop_code_i;
          tap_d     = TAP_W'(lat_eff - LAT_W'(1));
          gen_d     = gen_init;
          sent_d    = '0;
          misr_d    = '0;
          vld_d     = '0;
          pass_d    = 1'b0;
          stopped_d = 1'b0;
        end
      end
      S_LOAD: begin
        state_d = (num_q == '0) ? S_DRAIN : S_DRIVE;
      end
      S_DRIVE: begin
        case (mode_q)
          M_LFSR:  gen_d = step(gen_q);
          M_WALK:  gen_d = {gen_q[DW-2:0], gen_q[DW-1]};
          M_CONST: gen_d = gen_q;
          default: gen_d = gen_q + DW'(1);
        endcase
        sent_d = sent_q + CNT_W'(1);
        if (stop_hit) begin
          stopped_d = 1'b1;
        end
        if (last_pat || stop_hit) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!pending) begin
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        pass_d  = (misr_q == golden_sig_i);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_async_i) begin
    if (!rstn_async_i) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      num_q     <= '0;
      stop_en_q <= 1'b0;
      stop_q    <= '0;
      tap_q     <= '0;
      gen_q     <= '0;
      misr_q    <= '0;
      sent_q    <= '0;
      vld_q     <= '0;
      pass_q    <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      num_q     <= num_d;
      stop_en_q <= stop_en_d;
      stop_q    <= stop_d;
      tap_q     <= tap_d;
      gen_q     <= gen_d;
      misr_q    <= misr_d;
      sent_q    <= sent_d;
      vld_q     <= vld_d;
      pass_q    <= pass_d;
      stopped_q <= stopped_d;
    end
  end

  assign pattern_valid_o = drive_valid;
  assign pattern_o       = drive_valid ? gen_q : '0;
  assign signature_o     = misr_q;
  assign patterns_sent_o = sent_q;
  assign busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o          = (state_q == S_DONE);
  assign pass_o          = pass_q;
  assign stopped_o       = stopped_q;

endmodule
